// File: rtl/shifter_pipe_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter.
// Master drives operands and consumes results; slave is the shifter.
interface shifter_pipe_if #(
   parameter int DATA  = 32,
   parameter int SHAMT = 5,
   parameter int TAG   = 4
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [DATA-1:0]  in_data;
   logic [SHAMT-1:0] in_shamt;
   logic [2:0]       in_op;
   logic [TAG-1:0]   in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [DATA-1:0]  out_data;
   logic [TAG-1:0]   out_tag;

   modport master (
      output flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  flush, in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/shifter_pipe.sv
// Streaming barrel shifter: log2(DATA) shift levels split over REGS
// register stages, per-transaction SLL/SRL/SRA/ROL/ROR, valid/ready flow.
module shifter_pipe #(
   parameter int DATA  = 32,
   parameter int SHAMT = 5,
   parameter int REGS  = 2,
   parameter int TAG   = 4
) (
   input logic           clk,
   input logic           reset,
   shifter_pipe_if.slave bus
);
   localparam int L    = $clog2(DATA);
   localparam int BASE = L / REGS;
   localparam int REM  = L % REGS;

   typedef struct packed {
      logic [DATA-1:0] d;
      logic [L-1:0]    sh;
      logic            rot;
      logic            right;
      logic            fill;
      logic [TAG-1:0]  tag;
   } ent_t;

   ent_t            st [REGS];
   ent_t            nx [REGS];
   ent_t            ent;
   logic [REGS-1:0] v;
   logic [REGS-1:0] adv;
   logic            ovf;

   // Earlier groups take one extra level when L does not divide evenly.
   function automatic int grp(input int k);
      if (k < REM * (BASE + 1))
         return k / (BASE + 1);
      return REM + (k - REM * (BASE + 1)) / BASE;
   endfunction

   function automatic logic [DATA-1:0] lvl(
      input logic [DATA-1:0] d,
      input int              k,
      input logic            rot,
      input logic            right,
      input logic            fill
   );
      logic [2*DATA-1:0] w;
      logic [DATA-1:0]   lo;
      logic [DATA-1:0]   r;
      lo = rot ? d : {DATA{fill}};
      if (right) begin
         w = {lo, d} >> (1 << k);
         r = w[DATA-1:0];
      end else begin
         w = {d, lo} << (1 << k);
         r = w[2*DATA-1:DATA];
      end
      return r;
   endfunction

   assign ovf = (bus.in_shamt >> L) != '0;

   // Out-of-range logical/arith shifts collapse to the fill word up front.
   always_comb begin
      ent.rot   = bus.in_op[2];
      ent.right = bus.in_op[0];
      ent.fill  = bus.in_op[1] & bus.in_op[0] & ~bus.in_op[2]
                & bus.in_data[DATA-1];
      ent.sh    = bus.in_shamt[L-1:0];
      ent.tag   = bus.in_tag;
      ent.d     = (ovf & ~bus.in_op[2]) ? {DATA{ent.fill}} : bus.in_data;
   end

   always_comb begin
      nx[0] = ent;
      for (int g = 1; g < REGS; g++)
         nx[g] = st[g-1];
      for (int g = 0; g < REGS; g++)
         for (int k = 0; k < L; k++)
            if (grp(k) == g && nx[g].sh[k])
               nx[g].d = lvl(nx[g].d, k, nx[g].rot, nx[g].right, nx[g].fill);
   end

   always_comb begin
      logic go;
      go  = bus.out_ready;
      adv = '0;
      for (int i = REGS - 1; i >= 0; i--) begin
         adv[i] = v[i] & go;
         go     = ~v[i] | go;
      end
   end

   assign bus.in_ready  = ~reset & ~bus.flush & (~v[0] | adv[0]);
   assign bus.out_valid = v[REGS-1];
   assign bus.out_data  = st[REGS-1].d;
   assign bus.out_tag   = st[REGS-1].tag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v <= '0;
         for (int i = 0; i < REGS; i++)
            st[i] <= '0;
      end else if (bus.flush) begin
         v <= '0;
      end else begin
         if (~v[0] | adv[0]) begin
            v[0] <= bus.in_valid;
            if (bus.in_valid)
               st[0] <= nx[0];
         end
         for (int i = 1; i < REGS; i++)
            if (~v[i] | adv[i]) begin
               v[i] <= v[i-1];
               if (v[i-1])
                  st[i] <= nx[i];
            end
      end
   end
endmodule
